// File: rtl/router_arbiter_wrr_pkg.sv
// ---------------------------------------------------------------------------
// router_arbiter_pkg
// Shared types and helpers for the weighted round-robin output-port arbiter.
//   arb_state_e : arbiter FSM state (idle / locked on a packet)
//   port_idx_w  : width of a port index for a given port count (min 1 bit)
// ---------------------------------------------------------------------------
package router_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int port_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/router_arbiter_wrr_if.sv
// ---------------------------------------------------------------------------
// router_arbiter_wrr_if
// Handshake bundle between the input-port route-compute logic (master) and
// the output-port arbiter (slave).
//   request[NUM_PORTS]        input ports wanting this output
//   forwarding_head / _tail   head / tail flit crosses the crossbar this cycle
//   weight[NUM_PORTS][WEIGHT_W] packets-per-turn per port (0 acts as 1)
//   grant[NUM_PORTS]          one-hot selected input (or zero)
//   grant_valid               a new packet may start
//   owner                     index of port holding / winning the output
//   locked                    a packet is in flight
// ---------------------------------------------------------------------------
interface router_arbiter_wrr_if #(
    parameter int NUM_PORTS = 5,
    parameter int WEIGHT_W  = 3
);
    import router_arbiter_pkg::*;

    localparam int IDX_W = port_idx_w(NUM_PORTS);

    logic [NUM_PORTS-1:0]               request;
    logic                               forwarding_head;
    logic                               forwarding_tail;
    logic [NUM_PORTS-1:0][WEIGHT_W-1:0] weight;
    logic [NUM_PORTS-1:0]               grant;
    logic                               grant_valid;
    logic [IDX_W-1:0]                   owner;
    logic                               locked;

    modport master (
        output request, forwarding_head, forwarding_tail, weight,
        input  grant, grant_valid, owner, locked
    );

    modport slave (
        input  request, forwarding_head, forwarding_tail, weight,
        output grant, grant_valid, owner, locked
    );

endinterface

// File: rtl/router_arbiter_wrr_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin pick: rotate request so that port `ptr` sits at
// bit 0, take the lowest set bit, then rotate the index back.
//   request    : per-port request vector
//   ptr        : highest-priority port (must be < NUM_PORTS)
//   winner_oh  : one-hot winner, zero when no request
//   winner_idx : winner index (0 when no request)
//   any        : at least one request present
// ---------------------------------------------------------------------------
module rr_priority_picker
    import router_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = 5,
    localparam int IDX_W     = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] winner_oh,
    output logic [IDX_W-1:0]     winner_idx,
    output logic                 any
);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [2*NUM_PORTS-1:0] req_shift;
    logic [NUM_PORTS-1:0]   req_rot;
    logic [IDX_W-1:0]       first_rot;
    logic                   found;
    logic [IDX_W:0]         idx_sum;

    // Doubling the vector turns the rotate into a plain right shift.
    assign req_dbl   = {request, request};
    assign req_shift = req_dbl >> ptr;
    assign req_rot   = req_shift[NUM_PORTS-1:0];

    // Fixed-priority find-first; descending loop so the lowest bit wins.
    always_comb begin
        first_rot = '0;
        found     = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                first_rot = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

    // Rotate back: (first_rot + ptr) mod NUM_PORTS, both operands < NUM_PORTS.
    always_comb begin
        idx_sum = {1'b0, first_rot} + {1'b0, ptr};
        if (idx_sum >= (IDX_W+1)'(NUM_PORTS))
            idx_sum = idx_sum - (IDX_W+1)'(NUM_PORTS);
    end

    assign winner_idx = found ? idx_sum[IDX_W-1:0] : '0;
    assign winner_oh  = found ? (NUM_PORTS'(1) << winner_idx) : '0;
    assign any        = found;

endmodule

// File: rtl/router_arbiter_wrr.sv
// ---------------------------------------------------------------------------
// router_arbiter_wrr
// N-input to 1-output wormhole arbiter for one router output port, with a
// round-robin pointer and optional weighted mode (several consecutive
// packets per turn). Grant is held on the owner from head to tail.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : router_arbiter_wrr_if.slave (request/head/tail/weight in,
//              grant/grant_valid/owner/locked out)
// ---------------------------------------------------------------------------
module router_arbiter_wrr
    import router_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int WEIGHT_W  = 3,
    parameter int WEIGHTED  = 0
) (
    input  logic               clk,
    input  logic               rst,
    router_arbiter_wrr_if.slave bus
);

    localparam int IDX_W = port_idx_w(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [WEIGHT_W-1:0]  count_q, count_d;

    logic [NUM_PORTS-1:0] winner_oh;
    logic [IDX_W-1:0]     winner_idx;
    logic                 req_any;

    logic                 upd;       // apply priority update this cycle
    logic [IDX_W-1:0]     served;    // port whose packet just completed
    logic [IDX_W-1:0]     served_nxt;
    logic [WEIGHT_W-1:0]  w_eff;
    logic [WEIGHT_W:0]    cnt_inc;   // one extra bit so count+1 never wraps

    rr_priority_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .request    (bus.request),
        .ptr        (ptr_q),
        .winner_oh  (winner_oh),
        .winner_idx (winner_idx),
        .any        (req_any)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            count_q <= count_d;
        end
    end

    // Next-state: lock on a multi-flit head, release on tail. A single-flit
    // packet (head+tail together) never leaves idle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        upd     = 1'b0;
        served  = winner_idx;
        case (state_q)
            ARB_IDLE: begin
                if (bus.forwarding_head && req_any) begin
                    if (bus.forwarding_tail) begin
                        upd = 1'b1;
                    end else begin
                        state_d = ARB_LOCKED;
                        owner_d = winner_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                if (bus.forwarding_tail) begin
                    state_d = ARB_IDLE;
                    upd     = 1'b1;
                    served  = owner_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Priority update. Weight is sampled only here, so a weight change
    // mid-turn is seen at the next tail.
    always_comb begin
        ptr_d      = ptr_q;
        count_d    = count_q;
        served_nxt = (served == IDX_W'(NUM_PORTS - 1)) ? '0 : served + 1'b1;
        w_eff      = (bus.weight[served] == '0) ? WEIGHT_W'(1) : bus.weight[served];
        cnt_inc    = {1'b0, count_q} + 1'b1;
        if (upd) begin
            if (WEIGHTED == 0) begin
                ptr_d = served_nxt;
            end else if (served != ptr_q) begin
                // Pointer port was idle: the served requester starts a fresh quota.
                if (w_eff == WEIGHT_W'(1)) begin
                    ptr_d   = served_nxt;
                    count_d = '0;
                end else begin
                    ptr_d   = served;
                    count_d = WEIGHT_W'(1);
                end
            end else if (cnt_inc >= {1'b0, w_eff}) begin
                ptr_d   = served_nxt;
                count_d = '0;
            end else begin
                count_d = cnt_inc[WEIGHT_W-1:0];
            end
        end
    end

    // Outputs
    always_comb begin
        bus.locked      = (state_q == ARB_LOCKED);
        bus.grant       = '0;
        bus.owner       = ptr_q;
        bus.grant_valid = 1'b0;
        if (state_q == ARB_LOCKED) begin
            bus.grant = NUM_PORTS'(1) << owner_q;
            bus.owner = owner_q;
        end else begin
            bus.grant_valid = req_any;
            if (req_any) begin
                bus.grant = winner_oh;
                bus.owner = winner_idx;
            end
        end
    end

    // Protocol checks
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.grant))
        else $error("grant not one-hot");

    a_head_allowed: assert property (@(posedge clk) disable iff (rst)
        bus.forwarding_head |-> (bus.grant_valid || bus.locked))
        else $error("head without grant_valid");

    a_no_head_locked: assert property (@(posedge clk) disable iff (rst)
        bus.locked |-> !bus.forwarding_head)
        else $error("head while locked");

    a_owner_req: assert property (@(posedge clk) disable iff (rst)
        bus.locked |-> bus.request[owner_q])
        else $warning("owner dropped request while locked");

endmodule
